flush_control_unit: RTL and testbench

- Parametrised control-hazard squash controller for the LC-3b pipeline.
- Sits between the decode/execute control path and downstream stage controls.
- On a taken redirect from any of NUM_SRC sources (branch, JMP, JSR, TRAP, ...), zeroes the NUM_CTRL side-effect control bits for FLUSH_DEPTH instruction slots.
- Each slot occupied by a load (LDR/LDB/LDI) is stretched by one extra squash cycle when LOAD_WAIT=1.

---
 rtl/flush_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_flush_control_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flush_control_unit.sv
// -----------------------------------------------------------------------------
// flush_control_unit
//
// Control-hazard squash controller for the LC-3b pipeline. When any redirect
// source fires (branch, JMP, JSR, TRAP, ...) the following FLUSH_DEPTH
// wrong-path instruction slots have their side-effect control bits and
// redirect bits forced to zero. When LOAD_WAIT=1, a slot holding a load
// (LDR/LDB/LDI) is squashed for one extra cycle. The redirecting instruction
// itself always passes through unsquashed, with zero-cycle latency.
//
// Optional feature macro: FLUSH_STATS_EN
//   defined   -> flush_count / squash_cycles are live saturating counters,
//                cleared by stats_clear or reset.
//   undefined -> both counters are tied to 0, stats_clear is ignored.
//
// Ports:
//   clk           in   pipeline clock
//   reset_n       in   asynchronous active-low reset
//   stall         in   pipeline stall, freezes FSM progress
//   redirect_in   in   [NUM_SRC]  per-source redirect requests
//   ctrl_in       in   [NUM_CTRL] raw side-effect control bits
//   slot_opcode   in   [4]        opcode of the instruction in the monitored slot
//   ctrl_out      out  [NUM_CTRL] squashed control bits
//   redirect_out  out  [NUM_SRC]  squashed redirect bits
//   flush_active  out  1 while a squash state is active
//   flush_slot    out  current slot index (0 when idle)
//   stats_clear   in   synchronous statistics clear
//   flush_count   out  [16] redirect events accepted
//   squash_cycles out  [16] cycles with flush_active=1
// -----------------------------------------------------------------------------
module flush_control_unit #(
    parameter int FLUSH_DEPTH = 3,
    parameter int NUM_CTRL    = 3,
    parameter int NUM_SRC     = 4,
    parameter int LOAD_WAIT   = 1
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               stall,
    input  logic [NUM_SRC-1:0]                 redirect_in,
    input  logic [NUM_CTRL-1:0]                ctrl_in,
    input  logic [3:0]                         slot_opcode,
    output logic [NUM_CTRL-1:0]                ctrl_out,
    output logic [NUM_SRC-1:0]                 redirect_out,
    output logic                               flush_active,
    output logic [$clog2(FLUSH_DEPTH+1)-1:0]   flush_slot,
    input  logic                               stats_clear,
    output logic [15:0]                        flush_count,
    output logic [15:0]                        squash_cycles
);

    localparam int SLOT_W = $clog2(FLUSH_DEPTH + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FLUSH_DEPTH);
    localparam logic [SLOT_W-1:0] ONE_SLOT  = SLOT_W'(1);

    // LC-3b load opcodes (lc3b_opcode encodings)
    localparam logic [3:0] OP_LDB = 4'b0010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;

    generate
        if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > 15) begin : g_bad_depth
            $error("flush_control_unit: FLUSH_DEPTH must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FLUSH = 2'b01,
        ST_WAIT  = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q,  slot_d;
    logic                is_load;
    logic                flush_start;

    assign is_load = (slot_opcode == OP_LDR) || (slot_opcode == OP_LDB) ||
                     (slot_opcode == OP_LDI);

    // NOTE: every signal written here gets a default first, so no path through
    // the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        flush_start  = 1'b0;
        ctrl_out     = '0;
        redirect_out = '0;
        flush_active = 1'b1;
        flush_slot   = slot_q;

        case (state_q)
            ST_IDLE: begin
                ctrl_out     = ctrl_in;
                redirect_out = redirect_in;
                flush_active = 1'b0;
                flush_slot   = '0;
                // A stalled redirect is simply re-evaluated next cycle.
                if (|redirect_in && !stall) begin
                    state_d     = ST_FLUSH;
                    slot_d      = ONE_SLOT;
                    flush_start = 1'b1;
                end
            end

            ST_FLUSH: begin
                if (!stall) begin
                    if (LOAD_WAIT != 0 && is_load) begin
                        state_d = ST_WAIT;
                    end else if (slot_q >= LAST_SLOT) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end else begin
                        slot_d  = slot_q + ONE_SLOT;
                    end
                end
            end

            ST_WAIT: begin
                if (!stall) begin
                    if (slot_q >= LAST_SLOT) begin
                        state_d = ST_IDLE;
                        slot_d  = '0;
                    end else begin
                        state_d = ST_FLUSH;
                        slot_d  = slot_q + ONE_SLOT;
                    end
                end
            end

            default: begin
                // Illegal encoding: keep outputs squashed and recover to IDLE.
                state_d    = ST_IDLE;
                slot_d     = '0;
                flush_slot = '0;
            end
        endcase

        // Outputs are combinational, so reset must gate them directly to
        // reach their reset values without waiting for a clock.
        if (!reset_n) begin
            ctrl_out     = '0;
            redirect_out = '0;
            flush_active = 1'b0;
            flush_slot   = '0;
            flush_start  = 1'b0;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

`ifdef FLUSH_STATS_EN
    logic [15:0] flush_count_q,   flush_count_d;
    logic [15:0] squash_cycles_q, squash_cycles_d;

    always_comb begin
        flush_count_d   = flush_count_q;
        squash_cycles_d = squash_cycles_q;
        if (stats_clear) begin
            // Clear takes priority over a same-cycle increment.
            flush_count_d   = '0;
            squash_cycles_d = '0;
        end else begin
            if (flush_start && flush_count_q != 16'hFFFF) begin
                flush_count_d = flush_count_q + 16'd1;
            end
            if (flush_active && squash_cycles_q != 16'hFFFF) begin
                squash_cycles_d = squash_cycles_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_count_q   <= '0;
            squash_cycles_q <= '0;
        end else begin
            flush_count_q   <= flush_count_d;
            squash_cycles_q <= squash_cycles_d;
        end
    end

    assign flush_count   = flush_count_q;
    assign squash_cycles = squash_cycles_q;
`else
    logic unused_stats;
    assign unused_stats  = stats_clear ^ flush_start;
    assign flush_count   = '0;
    assign squash_cycles = '0;
`endif

endmodule

// File: tb/tb_flush_control_unit.sv
module tb_flush_control_unit;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_LDI = 4'b1010;

    typedef struct {
        string       nm;
        logic [2:0]  ctrl_a;
        logic [3:0]  redir_a;
        logic        act_a;
        logic [1:0]  slot_a;
        logic [2:0]  ctrl_b;
        logic [3:0]  redir_b;
        logic        act_b;
        logic [1:0]  slot_b;
        logic        chk_ab_cnt;
        logic [2:0]  ctrl_5;
        logic [3:0]  redir_5;
        logic        act_5;
        logic [2:0]  slot_5;
        logic [15:0] fc_5;
        logic [15:0] sc_5;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic ab_clean;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the default unit (a) and the LOAD_WAIT=0 unit (b)
    logic       reset_n, stall, stats_clear;
    logic [3:0] redirect_in, slot_opcode;
    logic [2:0] ctrl_in;
    // Stimulus for the FLUSH_DEPTH=5 unit
    logic       reset_n5, stall5, clr5;
    logic [3:0] redir5, opc5;
    logic [2:0] ctrl5;

    logic [2:0]  ctrl_a, ctrl_b, ctrl_o5;
    logic [3:0]  redir_a, redir_b, redir_o5;
    logic        act_a, act_b, act_o5;
    logic [1:0]  slot_a, slot_b;
    logic [2:0]  slot_o5;
    logic [15:0] fc_a, sc_a, fc_b, sc_b, fc_o5, sc_o5;

    flush_control_unit dut_a (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_in(redirect_in),
        .ctrl_in(ctrl_in), .slot_opcode(slot_opcode), .ctrl_out(ctrl_a),
        .redirect_out(redir_a), .flush_active(act_a), .flush_slot(slot_a),
        .stats_clear(stats_clear), .flush_count(fc_a), .squash_cycles(sc_a)
    );

    flush_control_unit #(.LOAD_WAIT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_in(redirect_in),
        .ctrl_in(ctrl_in), .slot_opcode(slot_opcode), .ctrl_out(ctrl_b),
        .redirect_out(redir_b), .flush_active(act_b), .flush_slot(slot_b),
        .stats_clear(stats_clear), .flush_count(fc_b), .squash_cycles(sc_b)
    );

    flush_control_unit #(.FLUSH_DEPTH(5)) dut_5 (
        .clk(clk), .reset_n(reset_n5), .stall(stall5), .redirect_in(redir5),
        .ctrl_in(ctrl5), .slot_opcode(opc5), .ctrl_out(ctrl_o5),
        .redirect_out(redir_o5), .flush_active(act_o5), .flush_slot(slot_o5),
        .stats_clear(clr5), .flush_count(fc_o5), .squash_cycles(sc_o5)
    );

    function automatic logic [15:0] stat(input int v);
`ifdef FLUSH_STATS_EN
        return 16'(v);
`else
        return 16'(v - v);
`endif
    endfunction

    task automatic check(input string nm, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitor: every sampled cycle with a pending expectation is compared.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, ".a_ctrl"},  16'(ctrl_a),  16'(e.ctrl_a));
            check({e.nm, ".a_redir"}, 16'(redir_a), 16'(e.redir_a));
            check({e.nm, ".a_act"},   16'(act_a),   16'(e.act_a));
            check({e.nm, ".a_slot"},  16'(slot_a),  16'(e.slot_a));
            check({e.nm, ".b_ctrl"},  16'(ctrl_b),  16'(e.ctrl_b));
            check({e.nm, ".b_redir"}, 16'(redir_b), 16'(e.redir_b));
            check({e.nm, ".b_act"},   16'(act_b),   16'(e.act_b));
            check({e.nm, ".b_slot"},  16'(slot_b),  16'(e.slot_b));
            if (e.chk_ab_cnt) begin
                check({e.nm, ".a_fc"}, fc_a, 16'd0);
                check({e.nm, ".a_sc"}, sc_a, 16'd0);
                check({e.nm, ".b_fc"}, fc_b, 16'd0);
                check({e.nm, ".b_sc"}, sc_b, 16'd0);
            end
            check({e.nm, ".d5_ctrl"},  16'(ctrl_o5),  16'(e.ctrl_5));
            check({e.nm, ".d5_redir"}, 16'(redir_o5), 16'(e.redir_5));
            check({e.nm, ".d5_act"},   16'(act_o5),   16'(e.act_5));
            check({e.nm, ".d5_slot"},  16'(slot_o5),  16'(e.slot_5));
            check({e.nm, ".d5_fc"},    fc_o5,         e.fc_5);
            check({e.nm, ".d5_sc"},    sc_o5,         e.sc_5);
        end
    end

    // Main-phase vector for units a/b; the depth-5 unit is held in reset.
    task automatic step(input string nm, input logic rst, input logic stl,
                        input logic [3:0] rd, input logic [2:0] ci, input logic [3:0] op,
                        input logic [2:0] e_ctrl, input logic [3:0] e_redir,
                        input logic e_act, input logic [1:0] e_slot,
                        input logic b_act, input logic [1:0] b_slot);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = rst; stall = stl; redirect_in = rd; ctrl_in = ci; slot_opcode = op;
        e.nm = nm;
        e.ctrl_a = e_ctrl; e.redir_a = e_redir; e.act_a = e_act; e.slot_a = e_slot;
        e.ctrl_b  = (rst && !b_act) ? ci : 3'b000;
        e.redir_b = (rst && !b_act) ? rd : 4'b0000;
        e.act_b = b_act; e.slot_b = b_slot;
        e.chk_ab_cnt = ab_clean;
        e.ctrl_5 = 3'b000; e.redir_5 = 4'b0000; e.act_5 = 1'b0; e.slot_5 = 3'd0;
        e.fc_5 = 16'd0; e.sc_5 = 16'd0;
        sb.push_back(e);
    endtask

    // Statistics-phase vector for the depth-5 unit; units a/b sit idle.
    task automatic step5(input string nm, input logic [3:0] rd, input logic [3:0] op,
                         input logic clr, input logic act, input logic [2:0] slot,
                         input int fc, input int sc);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n = 1'b1; stall = 1'b0; redirect_in = 4'b0; ctrl_in = 3'b0; slot_opcode = OP_ADD;
        reset_n5 = 1'b1; redir5 = rd; opc5 = op; clr5 = clr;
        e.nm = nm;
        e.ctrl_a = 3'b000; e.redir_a = 4'b0000; e.act_a = 1'b0; e.slot_a = 2'd0;
        e.ctrl_b = 3'b000; e.redir_b = 4'b0000; e.act_b = 1'b0; e.slot_b = 2'd0;
        e.chk_ab_cnt = 1'b1;
        e.ctrl_5  = act ? 3'b000 : 3'b111;
        e.redir_5 = act ? 4'b0000 : rd;
        e.act_5 = act; e.slot_5 = slot;
        e.fc_5 = stat(fc); e.sc_5 = stat(sc);
        sb.push_back(e);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    initial begin
        reset_n = 1'b0; stall = 1'b0; stats_clear = 1'b0;
        redirect_in = 4'b0; ctrl_in = 3'b0; slot_opcode = OP_ADD;
        reset_n5 = 1'b0; stall5 = 1'b0; clr5 = 1'b0;
        redir5 = 4'b0001; ctrl5 = 3'b111; opc5 = OP_ADD;
        ab_clean = 1'b1;

        step("rst_hold",          0, 0, 4'b0011, 3'b101, OP_ADD, 3'b101 & 3'b000, 4'b0000, 0, 0, 0, 0);
        ab_clean = 1'b0;
        // Basic flush of 3 slots, with a redirect during the last slot ignored
        step("idle_pass",         1, 0, 4'b0000, 3'b110, OP_ADD, 3'b110, 4'b0000, 0, 0, 0, 0);
        step("redir_cycle",       1, 0, 4'b0001, 3'b111, OP_ADD, 3'b111, 4'b0001, 0, 0, 0, 0);
        step("flush1",            1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 1, 1, 1);
        step("flush2",            1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 2, 1, 2);
        step("flush3_late_redir", 1, 0, 4'b0100, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 3, 1, 3);
        step("back_idle",         1, 0, 4'b0000, 3'b011, OP_ADD, 3'b011, 4'b0000, 0, 0, 0, 0);
        // Load in slot 1: a waits one extra cycle, b does not
        step("ld_redir",          1, 0, 4'b0010, 3'b101, OP_ADD, 3'b101, 4'b0010, 0, 0, 0, 0);
        step("ld_flush1",         1, 0, 4'b0000, 3'b111, OP_LDR, 3'b000, 4'b0000, 1, 1, 1, 1);
        step("ld_wait1",          1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 1, 1, 2);
        step("ld_flush2",         1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 2, 1, 3);
        step("ld_flush3",         1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 3, 0, 0);
        step("ld_idle",           1, 0, 4'b0000, 3'b010, OP_ADD, 3'b010, 4'b0000, 0, 0, 0, 0);
        // Stall for two cycles in slot 2
        step("st_redir",          1, 0, 4'b0001, 3'b111, OP_ADD, 3'b111, 4'b0001, 0, 0, 0, 0);
        step("st_flush1",         1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 1, 1, 1);
        step("st_flush2a",        1, 1, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 2, 1, 2);
        step("st_flush2b",        1, 1, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 2, 1, 2);
        step("st_flush2c",        1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 2, 1, 2);
        step("st_flush3",         1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 3, 1, 3);
        // Stalled redirect in IDLE is held off, then accepted
        step("idle_stall_redir",  1, 1, 4'b0001, 3'b100, OP_ADD, 3'b100, 4'b0001, 0, 0, 0, 0);
        step("held_redir",        1, 0, 4'b0001, 3'b100, OP_ADD, 3'b100, 4'b0001, 0, 0, 0, 0);
        // Wrong-path redirect during slot 1 is dropped
        step("wp_redir_f1",       1, 0, 4'b1000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 1, 1, 1);
        step("wp_f2",             1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 2, 1, 2);
        step("wp_f3",             1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 3, 1, 3);
        step("wp_idle",           1, 0, 4'b0000, 3'b001, OP_ADD, 3'b001, 4'b0000, 0, 0, 0, 0);
        step("wp_no_requeue",     1, 0, 4'b0000, 3'b110, OP_ADD, 3'b110, 4'b0000, 0, 0, 0, 0);
        // Asynchronous reset while held in slot 2
        step("rs_redir",          1, 0, 4'b0001, 3'b111, OP_ADD, 3'b111, 4'b0001, 0, 0, 0, 0);
        step("rs_f1",             1, 0, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 1, 1, 1);
        step("rs_f2_stall",       1, 1, 4'b0000, 3'b111, OP_ADD, 3'b000, 4'b0000, 1, 2, 1, 2);
        ab_clean = 1'b1;
        step("rs_async",          0, 1, 4'b0010, 3'b111, OP_ADD, 3'b000, 4'b0000, 0, 0, 0, 0);
        step("rs_release",        1, 0, 4'b0000, 3'b101, OP_ADD, 3'b101, 4'b0000, 0, 0, 0, 0);
        step("rs_idle",           1, 0, 4'b0000, 3'b010, OP_ADD, 3'b010, 4'b0000, 0, 0, 0, 0);

        // Depth-5 unit: two redirects, one load slot, then clears
        step5("s_idle",     4'b0000, OP_ADD, 0, 0, 0, 0, 0);
        step5("s_redir1",   4'b0001, OP_ADD, 0, 0, 0, 0, 0);
        step5("s1_f1",      4'b0000, OP_ADD, 0, 1, 1, 1, 0);
        step5("s1_f2_ldi",  4'b0000, OP_LDI, 0, 1, 2, 1, 1);
        step5("s1_w2",      4'b0000, OP_ADD, 0, 1, 2, 1, 2);
        step5("s1_f3",      4'b0000, OP_ADD, 0, 1, 3, 1, 3);
        step5("s1_f4",      4'b0000, OP_ADD, 0, 1, 4, 1, 4);
        step5("s1_f5",      4'b0000, OP_ADD, 0, 1, 5, 1, 5);
        step5("s_redir2",   4'b0001, OP_ADD, 0, 0, 0, 1, 6);
        step5("s2_f1",      4'b0000, OP_ADD, 0, 1, 1, 2, 6);
        step5("s2_f2",      4'b0000, OP_ADD, 0, 1, 2, 2, 7);
        step5("s2_f3",      4'b0000, OP_ADD, 0, 1, 3, 2, 8);
        step5("s2_f4",      4'b0000, OP_ADD, 0, 1, 4, 2, 9);
        step5("s2_f5",      4'b0000, OP_ADD, 0, 1, 5, 2, 10);
        step5("s_totals",   4'b0000, OP_ADD, 1, 0, 0, 2, 11);
        step5("s_cleared",  4'b0001, OP_ADD, 1, 0, 0, 0, 0);
        step5("s_clr_wins", 4'b0000, OP_ADD, 0, 1, 1, 0, 0);
        step5("s3_f2",      4'b0000, OP_ADD, 0, 1, 2, 0, 1);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        summary();
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $fatal(1, "watchdog expired");
    end

endmodule
